pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 11, ROM address width.
REQ-002 Parameter STACK_DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port ldpc  input  1  PC update enable from control_unit.
REQ-006 Port selpc  input  1  when 1, load naddress; when 0, increment.
REQ-007 Port naddress  input  AW  jump/call/return target.
REQ-008 Port wr_en  input  1  push return address.
REQ-009 Port rd_en  input  1  pop return address.
REQ-010 Port pc_addr  output  AW  registered ROM fetch address.
REQ-011 Port stack_addr  output  AW  registered value of the most recently popped entry.
REQ-012 Port depth  output  $clog2(STACK_DEPTH)+1  entries currently held.
REQ-013 Port stack_full / stack_empty  output  1 each  depth==STACK_DEPTH / depth==0, combinational from depth.
REQ-014 Port stack_ovf / stack_unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-015 ldpc=1, selpc=0: pc_addr <= pc_addr+1 modulo 2^AW (0x7FF -> 0x000).
REQ-016 ldpc=1, selpc=1: pc_addr <= naddress.
REQ-017 ldpc=0: pc_addr holds; selpc and naddress are ignored.
REQ-018 Push (wr_en=1, rd_en=0, not full): store pc_addr+1 (mod 2^AW, the return address) at index depth, depth <= depth+1, same edge as the PC load.
REQ-019 Pop (rd_en=1, wr_en=0, not empty): stack_addr <= entry[depth-1], depth <= depth-1; new stack_addr is visible the cycle after the pop edge and holds until the next pop.
REQ-020 Push when full: entry discarded, depth unchanged, stack_ovf <= 1; PC update still occurs.
REQ-021 Pop when empty: depth unchanged, stack_addr <= 0, stack_unf <= 1.
REQ-022 wr_en and rd_en together, not empty: stack_addr <= entry[depth-1], entry[depth-1] <= pc_addr+1, depth unchanged, no error flag.
REQ-023 wr_en and rd_en together, empty: push only (REQ-018), stack_addr <= 0, stack_unf <= 1.
REQ-024 stack_ovf/stack_unf clear only on reset.
REQ-025 Pop-to-use latency is one cycle: rd_en asserted in decode yields a valid stack_addr in the following execute cycle.
REQ-026 Stack storage entries are not reset; only depth-qualified entries are ever read.

Reset
REQ-027 rst=1 at a clock edge: pc_addr=0, stack_addr=0, depth=0, stack_ovf=0, stack_unf=0; this overrides ldpc, wr_en and rd_en in the same cycle.
REQ-028 Reset mid-call sequence discards all stacked entries; the first fetch after reset is from address 0.

Structure
REQ-029 The shared package SHALL hold AW, STACK_DEPTH defaults and RESET_VECTOR (0).
REQ-030 The return-address LIFO SHALL be a sub-module named call_stack (storage, depth counter, full/empty, error flags); pc_sequencer holds the PC register and the arbitration logic.

Verification
REQ-031 Reset, then 4 cycles of ldpc=1/selpc=0 -> pc_addr 0x001,0x002,0x003,0x004; one cycle ldpc=0 -> holds 0x004.
REQ-032 pc_addr=0x7FF, ldpc=1, selpc=0 -> pc_addr=0x000, no flag change.
REQ-033 pc_addr=0x010, wr_en=1, selpc=1, naddress=0x200 -> pc_addr=0x200, depth=1; next rd_en=1 -> stack_addr=0x011 the following cycle, depth=0.
REQ-034 9 pushes with STACK_DEPTH=8 -> depth=8, stack_full=1, stack_ovf=1; 8 pops return the 8 stored addresses in reverse order; 9th pop -> stack_addr=0, stack_unf=1, depth=0.
REQ-035 depth=2, top=0x123, pc_addr=0x050, wr_en=rd_en=1 -> stack_addr=0x123, top=0x051, depth=2; a mid-sequence rst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice.
//   AW_DEFAULT          : default ROM address width
//   STACK_DEPTH_DEFAULT : default number of return-address entries
//   RESET_VECTOR        : first fetch address after reset
//   stack_op_e          : return-stack operation selected from wr_en/rd_en
package pc_sequencer_pkg;

    localparam int unsigned AW_DEFAULT          = 11;
    localparam int unsigned STACK_DEPTH_DEFAULT = 8;
    localparam int unsigned RESET_VECTOR        = 0;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    // wr_en pushes, rd_en pops; both together replace the top entry.
    function automatic stack_op_e decode_stack_op(input logic wr_en, input logic rd_en);
        stack_op_e op;
        case ({rd_en, wr_en})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO.
//   clk, rst     : clock, synchronous active-high reset
//   i_op         : operation for this cycle (none/push/pop/swap)
//   i_push_data  : return address written on push/swap
//   o_top        : registered value of the most recently popped entry
//   o_depth      : number of entries held
//   o_full       : depth == DEPTH
//   o_empty      : depth == 0
//   o_ovf/o_unf  : sticky overflow/underflow flags, cleared only by reset
module call_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  stack_op_e                  i_op,
    input  logic [AW-1:0]              i_push_data,
    output logic [AW-1:0]              o_top,
    output logic [$clog2(DEPTH):0]     o_depth,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_ovf,
    output logic                       o_unf
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned DW = IW + 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic [AW-1:0] r_top;
    logic          r_ovf;
    logic          r_unf;

    logic          w_full;
    logic          w_empty;
    logic [IW-1:0] w_push_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_mem_we;
    logic [IW-1:0] w_mem_idx;

    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_empty    = (r_depth == '0);
    // When full the low bits wrap to 0, so top index still lands on DEPTH-1.
    assign w_push_idx = r_depth[IW-1:0];
    assign w_top_idx  = w_push_idx - IW'(1);

    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = w_push_idx;
        case (i_op)
            OP_PUSH: w_mem_we = !w_full;
            OP_SWAP: begin
                // Swap on an empty stack degenerates to a plain push.
                w_mem_we  = 1'b1;
                w_mem_idx = w_empty ? w_push_idx : w_top_idx;
            end
            default: ;
        endcase
    end

    // Storage is not reset; only depth-qualified entries are ever read.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_idx] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (i_op)
                OP_PUSH: begin
                    if (w_full) r_ovf   <= 1'b1;
                    else        r_depth <= r_depth + DW'(1);
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_top <= '0;
                        r_unf <= 1'b1;
                    end else begin
                        r_top   <= r_mem[w_top_idx];
                        r_depth <= r_depth - DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (w_empty) begin
                        r_top   <= '0;
                        r_unf   <= 1'b1;
                        r_depth <= r_depth + DW'(1);
                    end else begin
                        r_top <= r_mem[w_top_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_top   = r_top;
    assign o_depth = r_depth;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack.
//   clk, rst               : clock, synchronous active-high reset
//   ldpc                   : PC update enable
//   selpc                  : 1 = load naddress, 0 = increment
//   naddress               : jump/call/return target
//   wr_en / rd_en          : push return address (pc_addr+1) / pop
//   pc_addr                : registered ROM fetch address
//   stack_addr             : registered value of most recently popped entry
//   depth                  : entries currently held
//   stack_full/stack_empty : depth == STACK_DEPTH / depth == 0
//   stack_ovf/stack_unf    : sticky overflow/underflow flags
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW          = AW_DEFAULT,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ldpc,
    input  logic                          selpc,
    input  logic [AW-1:0]                 naddress,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [AW-1:0]                 pc_addr,
    output logic [AW-1:0]                 stack_addr,
    output logic [$clog2(STACK_DEPTH):0]  depth,
    output logic                          stack_full,
    output logic                          stack_empty,
    output logic                          stack_ovf,
    output logic                          stack_unf
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_ret_addr;
    stack_op_e     w_op;

    // Return address is the PC of the calling instruction plus one, wrapping.
    assign w_ret_addr = r_pc + AW'(1);
    assign w_op       = decode_stack_op(wr_en, rd_en);

    always_comb begin
        w_pc_next = r_pc;
        if (ldpc) begin
            w_pc_next = selpc ? naddress : w_ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= AW'(RESET_VECTOR);
        else     r_pc <= w_pc_next;
    end

    call_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk         (clk),
        .rst         (rst),
        .i_op        (w_op),
        .i_push_data (w_ret_addr),
        .o_top       (stack_addr),
        .o_depth     (depth),
        .o_full      (stack_full),
        .o_empty     (stack_empty),
        .o_ovf       (stack_ovf),
        .o_unf       (stack_unf)
    );

    assign pc_addr = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (AW=11, STACK_DEPTH=8).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ldpc = 1'b0;
    logic        selpc = 1'b0;
    logic [10:0] naddress = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [10:0] pc_addr;
    logic [10:0] stack_addr;
    logic [3:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_ovf;
    logic        stack_unf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        ldpc;
        logic        selpc;
        logic        wr;
        logic        rd;
        logic [10:0] na;
        logic [10:0] pc;
        logic [10:0] sa;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .AW          (11),
        .STACK_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ldpc        (ldpc),
        .selpc       (selpc),
        .naddress    (naddress),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .pc_addr     (pc_addr),
        .stack_addr  (stack_addr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic s, input logic w, input logic rd,
                       input logic [10:0] na, input logic [10:0] pc, input logic [10:0] sa,
                       input logic [3:0] d, input logic ovf, input logic unf);
        vec_t v;
        v.rst = r; v.ldpc = l; v.selpc = s; v.wr = w; v.rd = rd; v.na = na;
        v.pc = pc; v.sa = sa; v.depth = d; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; ldpc = v.ldpc; selpc = v.selpc; wr_en = v.wr; rd_en = v.rd; naddress = v.na;
        @(posedge clk);
        #1;
        check("pc_addr",     idx, 32'(pc_addr),     32'(v.pc));
        check("stack_addr",  idx, 32'(stack_addr),  32'(v.sa));
        check("depth",       idx, 32'(depth),       32'(v.depth));
        check("stack_full",  idx, 32'(stack_full),  32'(v.depth == 4'd8));
        check("stack_empty", idx, 32'(stack_empty), 32'(v.depth == 4'd0));
        check("stack_ovf",   idx, 32'(stack_ovf),   32'(v.ovf));
        check("stack_unf",   idx, 32'(stack_unf),   32'(v.unf));
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
        vecs.delete();
    endtask

    initial begin
        logic [10:0] ret[9];
        logic [10:0] prev_pc;
        vec_t v;

        // Reset, increment, hold, wrap, call and return.
        //  rst ld sel wr rd  naddr     pc      sa     d  ovf unf
        add(1, 0, 0, 0, 0, 11'h000, 11'h000, 11'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 11'h000, 11'h001, 11'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 11'h000, 11'h002, 11'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 11'h000, 11'h003, 11'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 11'h000, 11'h004, 11'h000, 0, 0, 0);
        add(0, 0, 1, 0, 0, 11'h3AA, 11'h004, 11'h000, 0, 0, 0);
        add(0, 1, 1, 0, 0, 11'h7FF, 11'h7FF, 11'h000, 0, 0, 0);
        add(0, 1, 0, 0, 0, 11'h000, 11'h000, 11'h000, 0, 0, 0);
        add(0, 1, 1, 0, 0, 11'h010, 11'h010, 11'h000, 0, 0, 0);
        add(0, 1, 1, 1, 0, 11'h200, 11'h200, 11'h000, 1, 0, 0);
        add(0, 0, 0, 0, 1, 11'h000, 11'h200, 11'h011, 0, 0, 0);
        run_table(0);

        // Nine calls into an 8-deep stack, then nine returns.
        prev_pc = 11'h200;
        for (int i = 0; i < 9; i++) begin
            ret[i] = prev_pc + 11'd1;
            v.rst = 0; v.ldpc = 1; v.selpc = 1; v.wr = 1; v.rd = 0;
            v.na = 11'(32'h40 * (i + 1) + 5);
            v.pc = v.na; v.sa = 11'h011;
            v.depth = (i < 8) ? 4'(i + 1) : 4'd8;
            v.ovf = (i == 8); v.unf = 0;
            apply(v, 100 + i);
            prev_pc = v.na;
        end
        for (int k = 0; k < 9; k++) begin
            v.rst = 0; v.ldpc = 0; v.selpc = 0; v.wr = 0; v.rd = 1; v.na = 11'h000;
            v.pc = prev_pc;
            v.sa = (k < 8) ? ret[7 - k] : 11'h000;
            v.depth = (k < 8) ? 4'(7 - k) : 4'd0;
            v.ovf = 1; v.unf = (k == 8);
            apply(v, 200 + k);
        end

        // Swap on a non-empty stack, reset mid-sequence, swap on empty stack.
        add(1, 0, 0, 0, 0, 11'h000, 11'h000, 11'h000, 0, 0, 0);
        add(0, 1, 1, 1, 0, 11'h122, 11'h122, 11'h000, 1, 0, 0);
        add(0, 1, 1, 1, 0, 11'h050, 11'h050, 11'h000, 2, 0, 0);
        add(0, 0, 0, 1, 1, 11'h000, 11'h050, 11'h123, 2, 0, 0);
        add(0, 0, 0, 0, 1, 11'h000, 11'h050, 11'h051, 1, 0, 0);
        add(1, 1, 0, 1, 0, 11'h000, 11'h000, 11'h000, 0, 0, 0);
        add(0, 0, 0, 0, 1, 11'h000, 11'h000, 11'h000, 0, 0, 1);
        add(0, 1, 0, 1, 1, 11'h000, 11'h001, 11'h000, 1, 0, 1);
        add(0, 0, 0, 0, 1, 11'h000, 11'h001, 11'h001, 0, 0, 1);
        add(1, 1, 1, 1, 1, 11'h555, 11'h000, 11'h000, 0, 0, 0);
        run_table(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
